// File: rtl/ahbl_sram_pkg.sv
// Shared AHB-Lite encodings and the byte-lane mask helper used by the SRAM slave.
package ahbl_sram_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SizeByte = 3'd0,
    SizeHalf = 3'd1,
    SizeWord = 3'd2
  } hsize_e;

  // Sizes above a word are folded onto a full-word access.
  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      SizeByte: mask = 4'b0001 << addr_lo;
      SizeHalf: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:  mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/sram_sp_bw.sv
// Single-port 32-bit SRAM with per-byte write enables and a registered read port.
// Behavioural stand-in for a technology macro; contents are not reset.
module sram_sp_bw #(
  parameter int unsigned Aw = 12
) (
  input  logic          clk_i,
  input  logic          cs_i,
  input  logic [3:0]    we_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  localparam int unsigned Depth = 2 ** Aw;

  logic [31:0] mem_q [Depth];

  // Read output only changes on a read so it holds across later writes.
  always_ff @(posedge clk_i) begin
    if (cs_i) begin
      if (we_i == 4'b0000) begin
        rdata_o <= mem_q[addr_i];
      end
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/ahbl_sram.sv
// AHB-Lite SRAM slave: zero-wait writes through a one-entry write buffer, forwarding of
// buffered bytes into read data, and a programmable number of read wait states.
module ahbl_sram
  import ahbl_sram_pkg::*;
#(
  parameter int unsigned AW = 14,
  parameter int unsigned WS = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  localparam int unsigned WordAw = AW - 2;

  logic accept, rd_accept;
  assign accept    = HSEL & HREADY & HTRANS[1];
  assign rd_accept = accept & ~HWRITE;

  // Address-phase registers
  logic [WordAw-1:0] addr_q, addr_d;
  logic [3:0]        mask_q, mask_d;
  logic              wr_dp_q, wr_dp_d;
  logic              rd_dp_q, rd_dp_d;

  // Write buffer
  logic              buf_valid_q, buf_valid_d;
  logic [WordAw-1:0] buf_addr_q, buf_addr_d;
  logic [3:0]        buf_mask_q, buf_mask_d;
  logic [31:0]       buf_data_q, buf_data_d;

  logic [1:0]        wait_q, wait_d;
  logic [31:0]       hrdata_q, hrdata_d;

  logic              mem_cs;
  logic [3:0]        mem_be;
  logic [WordAw-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata, merged;
  logic              fwd_hit;

  always_comb begin
    addr_d  = addr_q;
    mask_d  = mask_q;
    wr_dp_d = accept & HWRITE;
    rd_dp_d = rd_accept;
    if (accept) begin
      addr_d = HADDR[AW-1:2];
      mask_d = byte_mask(HSIZE, HADDR[1:0]);
    end
  end

  // Port arbitration: a read accept owns the port, so a coinciding write data phase is
  // parked in the buffer; the buffer drains on the next cycle without a read accept.
  always_comb begin
    mem_cs      = 1'b0;
    mem_be      = 4'b0000;
    mem_addr    = HADDR[AW-1:2];
    mem_wdata   = HWDATA;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_mask_d  = buf_mask_q;
    buf_data_d  = buf_data_q;
    if (rd_accept) begin
      mem_cs = 1'b1;
      if (wr_dp_q) begin
        buf_valid_d = 1'b1;
        buf_addr_d  = addr_q;
        buf_mask_d  = mask_q;
        buf_data_d  = HWDATA;
      end
    end else if (wr_dp_q) begin
      mem_cs   = 1'b1;
      mem_be   = mask_q;
      mem_addr = addr_q;
    end else if (buf_valid_q) begin
      mem_cs      = 1'b1;
      mem_be      = buf_mask_q;
      mem_addr    = buf_addr_q;
      mem_wdata   = buf_data_q;
      buf_valid_d = 1'b0;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (rd_accept) begin
      wait_d = 2'(WS);
    end else if (wait_q != 2'd0) begin
      wait_d = wait_q - 2'd1;
    end
  end

  assign fwd_hit = buf_valid_q && (buf_addr_q == addr_q);

  always_comb begin
    merged = mem_rdata;
    for (int b = 0; b < 4; b++) begin
      if (fwd_hit && buf_mask_q[b]) begin
        merged[8*b +: 8] = buf_data_q[8*b +: 8];
      end
    end
    hrdata_d = rd_dp_q ? merged : hrdata_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q      <= '0;
      mask_q      <= 4'b0000;
      wr_dp_q     <= 1'b0;
      rd_dp_q     <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_mask_q  <= 4'b0000;
      buf_data_q  <= 32'h0;
      wait_q      <= 2'd0;
      hrdata_q    <= 32'h0;
    end else begin
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      wr_dp_q     <= wr_dp_d;
      rd_dp_q     <= rd_dp_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_mask_q  <= buf_mask_d;
      buf_data_q  <= buf_data_d;
      wait_q      <= wait_d;
      hrdata_q    <= hrdata_d;
    end
  end

  sram_sp_bw #(
    .Aw(WordAw)
  ) u_sram (
    .clk_i  (HCLK),
    .cs_i   (mem_cs),
    .we_i   (mem_be),
    .addr_i (mem_addr),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );

  assign HRDATA    = hrdata_d;
  assign HREADYOUT = (wait_q == 2'd0);
  assign HRESP     = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:AW], HTRANS[0]};

endmodule

// File: tb/tb_ahbl_sram.sv
// Scoreboard bench for ahbl_sram: one instance with no read wait states, one with two.
module tb_ahbl_sram;
  import ahbl_sram_pkg::*;

  localparam int unsigned AW  = 14;
  localparam int          WS1 = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic [2:0]  hsize     [2];
  logic        hwrite    [2];
  logic [31:0] hwdata    [2];
  logic        hreadyout [2];
  logic [31:0] hrdata    [2];
  logic        hresp     [2];

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [2][4096];
  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];
  bit          rd_pend    [2];
  int          stall      [2];
  logic [31:0] last_rd    [2];
  bit          last_valid [2];
  int          ws_of      [2];

  always #5 clk = ~clk;

  ahbl_sram #(.AW(AW), .WS(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HSIZE(hsize[0]), .HWRITE(hwrite[0]), .HREADY(hreadyout[0]), .HWDATA(hwdata[0]),
    .HREADYOUT(hreadyout[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0])
  );

  ahbl_sram #(.AW(AW), .WS(WS1)) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HSIZE(hsize[1]), .HWRITE(hwrite[1]), .HREADY(hreadyout[1]), .HWDATA(hwdata[1]),
    .HREADYOUT(hreadyout[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1])
  );

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h at %0t", name, i, act, exp, $time);
    end
  endtask

  // Reference memory: byte-addressed view, address wraps modulo 2^AW.
  task automatic model_write(input int i, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] lanes);
    int nb;
    int a;
    int base;
    nb   = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
    a    = int'(addr % (32'd1 << AW));
    base = a - (a % nb);
    for (int k = 0; k < nb; k++) begin
      int b;
      b = base + k;
      model[i][b / 4][8*(b % 4) +: 8] = lanes[8*(b % 4) +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input int i, input logic [31:0] addr);
    return model[i][int'(addr % (32'd1 << AW)) / 4];
  endfunction

  function automatic logic [31:0] replicate(input logic [2:0] size, input logic [31:0] v);
    case (size)
      3'd0:    return {4{v[7:0]}};
      3'd1:    return {2{v[15:0]}};
      default: return v;
    endcase
  endfunction

  task automatic push_exp(input int i, input logic [31:0] v);
    if (i == 0) exp0.push_back(v);
    else exp1.push_back(v);
  endtask

  // Drives one address phase (held through stalls) and then its data phase.
  task automatic issue(input int i, input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [2:0] size, input logic [31:0] val);
    logic [31:0] lanes;
    bit          rdy;
    int          guard;
    lanes     = replicate(size, val);
    hsel[i]   = sel;
    htrans[i] = trans;
    haddr[i]  = addr;
    hsize[i]  = size;
    hwrite[i] = wr;
    if (sel && trans[1]) begin
      if (wr) model_write(i, addr, size, lanes);
      else push_exp(i, model_read(i, addr));
    end
    guard = 0;
    do begin
      @(negedge clk);
      rdy = hreadyout[i];
      @(posedge clk);
      guard++;
    end while (!rdy && guard < 32);
    if (!rdy) begin
      miscompares++;
      $display("FAIL stall_bound dut%0d: HREADYOUT low for %0d cycles, required <= %0d",
               i, guard, WS1);
    end
    #1;
    hwdata[i] = lanes;
    hsel[i]   = 1'b0;
    htrans[i] = TransIdle;
  endtask

  task automatic wr(input int i, input logic [31:0] a, input logic [2:0] sz,
                    input logic [31:0] v);
    issue(i, 1'b1, TransNonseq, 1'b1, a, sz, v);
  endtask

  task automatic rd(input int i, input logic [31:0] a);
    issue(i, 1'b1, TransNonseq, 1'b0, a, 3'd2, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic random_phase(input int i, input int n);
    for (int t = 0; t < n; t++) begin
      int          kind;
      int          nb;
      logic [2:0]  sz;
      logic [31:0] a;
      logic [31:0] v;
      logic [1:0]  tr;
      kind = $urandom_range(0, 9);
      sz   = 3'($urandom_range(0, 3));
      nb   = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
      a    = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) & ~32'(nb - 1));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_C000);
      v    = $urandom;
      tr   = ($urandom_range(0, 1) == 1) ? TransSeq : TransNonseq;
      if (kind <= 5) begin
        issue(i, 1'b1, tr, 1'b1, a, sz, v);
      end else if (kind <= 8) begin
        issue(i, 1'b1, tr, 1'b0, a, sz, v);
      end else if ($urandom_range(0, 1) == 1) begin
        issue(i, 1'b0, TransNonseq, 1'($urandom_range(0, 1)), a, sz, v);
      end else begin
        issue(i, 1'b1, 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, sz, v);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  // Monitor: compares read data whenever a read data phase completes.
  always @(negedge clk) begin : monitor
    logic [31:0] ev;
    bit          ok;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        check("reset_hreadyout", i, 32'(hreadyout[i]), 32'd1);
        check("reset_hrdata", i, hrdata[i], 32'd0);
        check("reset_hresp", i, 32'(hresp[i]), 32'd0);
        rd_pend[i]    = 1'b0;
        stall[i]      = 0;
        last_rd[i]    = 32'h0;
        last_valid[i] = 1'b1;
      end else begin
        if (rd_pend[i]) begin
          if (!hreadyout[i]) begin
            stall[i]++;
          end else begin
            ok = (i == 0) ? (exp0.size() != 0) : (exp1.size() != 0);
            ev = 32'h0;
            if (ok) ev = (i == 0) ? exp0.pop_front() : exp1.pop_front();
            if (!ok) begin
              miscompares++;
              $display("FAIL exp_underflow dut%0d: read completed with no expected value", i);
            end else begin
              check("rdata", i, hrdata[i], ev);
            end
            check("wait_states", i, 32'(stall[i]), 32'(ws_of[i]));
            check("hresp", i, 32'(hresp[i]), 32'd0);
            last_rd[i]    = ev;
            last_valid[i] = 1'b1;
            rd_pend[i]    = 1'b0;
            stall[i]      = 0;
          end
        end else begin
          check("idle_hreadyout", i, 32'(hreadyout[i]), 32'd1);
          if (last_valid[i]) check("hrdata_hold", i, hrdata[i], last_rd[i]);
        end
        if (hsel[i] && hreadyout[i] && htrans[i][1] && !hwrite[i]) rd_pend[i] = 1'b1;
      end
    end
    if (rst_n) begin
      assert (!(dut0.wr_dp_q && dut0.buf_valid_q)) else begin
        miscompares++;
        $display("FAIL port_conflict dut0: write data phase with buffer valid at %0t", $time);
      end
      assert (!(dut1.wr_dp_q && dut1.buf_valid_q)) else begin
        miscompares++;
        $display("FAIL port_conflict dut1: write data phase with buffer valid at %0t", $time);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    ws_of[0] = 0;
    ws_of[1] = WS1;
    rst_n    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      hsel[i]   = 1'b0;
      haddr[i]  = 32'h0;
      htrans[i] = TransIdle;
      hsize[i]  = 3'd2;
      hwrite[i] = 1'b0;
      hwdata[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Known contents for the first 32 words of both instances.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 32; w++) wr(i, 32'(w * 4), 3'd2, $urandom);
      idle(1);
    end

    // Zero-wait-state instance: directed cases
    wr(0, 32'h10, 3'd2, 32'h1234_5678);
    idle(1);
    rd(0, 32'h10);
    idle(1);
    wr(0, 32'h20, 3'd2, 32'hAABB_CCDD);
    rd(0, 32'h20);
    idle(1);
    rd(0, 32'h20);
    wr(0, 32'h30, 3'd2, 32'h0000_0000);
    wr(0, 32'h31, 3'd0, 32'h0000_0011);
    wr(0, 32'h32, 3'd1, 32'h0000_2233);
    rd(0, 32'h30);
    wr(0, (32'd1 << AW) + 32'h40, 3'd2, 32'h5A5A_5A5A);
    idle(2);
    rd(0, 32'h40);
    // Byte write forwarded into an immediately following read of the same word
    wr(0, 32'h52, 3'd0, 32'h0000_00E7);
    rd(0, 32'h50);
    rd(0, 32'h50);
    idle(1);

    // Wait-state instance: directed cases
    rd(1, 32'h10);
    idle(1);
    rd(1, 32'h14);
    rd(1, 32'h18);
    rd(1, 32'h1C);
    wr(1, 32'h20, 3'd2, 32'hAABB_CCDD);
    rd(1, 32'h20);
    wr(1, 32'h22, 3'd1, 32'h0000_9876);
    rd(1, 32'h20);
    idle(2);

    random_phase(0, 250);
    idle(2);
    random_phase(1, 200);
    idle(8);

    check("drain", 0, 32'(exp0.size()), 32'd0);
    check("drain", 1, 32'(exp1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
